// File: rtl/regfile_bus_responder_pkg.sv
// Shared types and default geometry for the register-file bus responder.
package regfile_bus_responder_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DEPTH      = 32;
  localparam int DEF_ZERO_REG   = 31;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_CAPT  = 3'd1,
    S_ACK      = 3'd2,
    S_RD_FETCH = 3'd3,
    S_RD_DRIVE = 3'd4,
    S_RD_ACK   = 3'd5
  } state_t;

  // States in which the responder owns the shared data bus.
  function automatic logic drives_bus(input state_t s);
    return (s == S_RD_DRIVE) || (s == S_RD_ACK);
  endfunction

endpackage

// File: rtl/regfile_bus_responder_if.sv
// Request/acknowledge handshake between the bus initiator and the responder.
interface regfile_bus_responder_if
  import regfile_bus_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ack;
  logic                  busy;
  logic                  err;

  modport master (output req, we, addr, input ack, busy, err);
  modport slave  (input req, we, addr, output ack, busy, err);

endinterface

// File: rtl/regfile_bus_responder_reg_bank.sv
// DEPTH x DATA_WIDTH register bank: one write port, one combinational read port,
// hardwired-zero register and out-of-range addresses masked here.
module regfile_bus_responder_reg_bank
  import regfile_bus_responder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ZERO_REG   = DEF_ZERO_REG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_ok;
  logic                  rd_ok;

  assign wr_ok = wen && (int'(waddr) < DEPTH) && (waddr != ZERO_ADDR);
  assign rd_ok = (int'(raddr) < DEPTH) && (raddr != ZERO_ADDR);

  // NOTE: the bank is cleared by the async reset because software relies on reading
  // zeros after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  assign rdata = rd_ok ? mem[raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/regfile_bus_responder.sv
// Responder end of the shared tristate register-file bus: 4-phase req/ack FSM,
// request edge qualifier, address latch, read holding register and bus driver.
module regfile_bus_responder
  import regfile_bus_responder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ZERO_REG   = DEF_ZERO_REG
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_bus_responder_if.slave  bus,
  inout  wire  [DATA_WIDTH-1:0]   data_bus
);

  state_t                state;
  state_t                state_nxt;
  logic                  req_q;
  logic                  start;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] out_reg;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  drive_en;
  logic                  addr_oor;
  logic                  wen;
  logic                  fetch;
  logic                  ack;
  logic                  busy;
  logic                  err;

  // A request must be seen low before it counts again; req_q resets high so a req
  // held across reset release is not mistaken for a new transaction.
  assign start    = (state == S_IDLE) && bus.req && !req_q;
  assign addr_oor = int'(addr_q) >= DEPTH;

  regfile_bus_responder_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .ZERO_REG   (ZERO_REG)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .wen   (wen),
    .waddr (addr_q),
    .wdata (data_bus),
    .raddr (addr_q),
    .rdata (rdata)
  );

  // NOTE: state lives in always_ff with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      req_q    <= 1'b1;
      addr_q   <= '0;
      out_reg  <= '0;
      drive_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      req_q    <= bus.req;
      drive_en <= drives_bus(state_nxt);
      if (start) addr_q  <= bus.addr;
      if (fetch) out_reg <= rdata;
    end
  end

  // The direction bit is carried by the state path chosen in IDLE, so only the
  // address needs an explicit latch.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    busy      = 1'b1;
    err       = 1'b0;
    wen       = 1'b0;
    fetch     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = bus.we ? S_WR_CAPT : S_RD_FETCH;
      end
      S_WR_CAPT: begin
        err       = addr_oor;
        wen       = bus.req;
        state_nxt = bus.req ? S_ACK : S_IDLE;
      end
      S_ACK: begin
        ack = 1'b1;
        if (!bus.req) state_nxt = S_IDLE;
      end
      S_RD_FETCH: begin
        err       = addr_oor;
        fetch     = 1'b1;
        state_nxt = bus.req ? S_RD_DRIVE : S_IDLE;
      end
      S_RD_DRIVE: begin
        state_nxt = bus.req ? S_RD_ACK : S_IDLE;
      end
      S_RD_ACK: begin
        ack = 1'b1;
        if (!bus.req) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.ack  = ack;
  assign bus.busy = busy;
  assign bus.err  = err;

  assign data_bus = drive_en ? out_reg : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_regfile_bus_responder.sv
// Scoreboard bench for regfile_bus_responder: a 32-deep and a 16-deep instance,
// expected read data queued at issue and compared when ack arrives.
module tb_regfile_bus_responder;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] tb_data;
  logic          tb_drive;
  logic          sel16;

  wire  [DW-1:0] bus_a;
  wire  [DW-1:0] bus_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model_a [32];
  logic [DW-1:0] model_b [16];
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  regfile_bus_responder_if #(.ADDR_WIDTH(AW)) if_a ();
  regfile_bus_responder_if #(.ADDR_WIDTH(AW)) if_b ();

  assign if_a.req  = req && !sel16;
  assign if_a.we   = we;
  assign if_a.addr = addr;
  assign if_b.req  = req && sel16;
  assign if_b.we   = we;
  assign if_b.addr = addr;

  assign bus_a = (tb_drive && !sel16) ? tb_data : 32'hzzzz_zzzz;
  assign bus_b = (tb_drive &&  sel16) ? tb_data : 32'hzzzz_zzzz;

  regfile_bus_responder #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .DEPTH (32), .ZERO_REG (31)
  ) dut_a (
    .clk (clk), .rst (rst), .bus (if_a), .data_bus (bus_a)
  );

  regfile_bus_responder #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .DEPTH (16), .ZERO_REG (31)
  ) dut_b (
    .clk (clk), .rst (rst), .bus (if_b), .data_bus (bus_b)
  );

  logic          rel_a, rel_b;
  logic          cur_ack, cur_busy, cur_err, cur_rel;
  logic [DW-1:0] cur_bus;

  assign rel_a    = (bus_a === 32'hzzzz_zzzz);
  assign rel_b    = (bus_b === 32'hzzzz_zzzz);
  assign cur_ack  = sel16 ? if_b.ack  : if_a.ack;
  assign cur_busy = sel16 ? if_b.busy : if_a.busy;
  assign cur_err  = sel16 ? if_b.err  : if_a.err;
  assign cur_rel  = sel16 ? rel_b     : rel_a;
  assign cur_bus  = sel16 ? bus_b     : bus_a;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input int a);
    if (a == 31) return '0;
    if (!sel16) return model_a[a];
    if (a >= 16) return '0;
    return model_b[a];
  endfunction

  task automatic model_wr(input int a, input logic [DW-1:0] d);
    if (a == 31) return;
    if (!sel16) model_a[a] = d;
    else if (a < 16) model_b[a] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_a[i] = '0;
    for (int i = 0; i < 16; i++) model_b[i] = '0;
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d, input logic exp_err);
    int lat  = 99;
    int errs = 0;
    @(posedge clk); #1;
    addr = AW'(a); we = 1'b1; tb_data = d; tb_drive = 1'b1; req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin addr = ~addr; we = 1'b0; end
      if (cur_err) errs++;
      if (cur_ack) begin lat = c; break; end
    end
    check($sformatf("wr%0d_latency", a), lat, 2);
    check($sformatf("wr%0d_err_pulses", a), errs, exp_err ? 1 : 0);
    model_wr(a, d);
    req = 1'b0; tb_drive = 1'b0;
    @(posedge clk); #1;
    check($sformatf("wr%0d_ack_busy_drop", a), {cur_ack, cur_busy}, 2'b00);
  endtask

  task automatic do_read(input int a, input logic exp_err, input logic hold);
    int   lat     = 99;
    int   errs    = 0;
    logic drv_pre = 1'b0;
    exp_q.push_back(model_rd(a));
    @(posedge clk); #1;
    addr = AW'(a); we = 1'b0; tb_drive = 1'b0; req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin addr = ~addr; we = 1'b1; end
      if (cur_err) errs++;
      if (cur_ack) begin lat = c; break; end
      drv_pre = !cur_rel;
    end
    check($sformatf("rd%0d_latency", a), lat, 3);
    check($sformatf("rd%0d_err_pulses", a), errs, exp_err ? 1 : 0);
    check($sformatf("rd%0d_driven_before_ack", a), drv_pre, 1'b1);
    if (exp_q.size() > 0) check($sformatf("rd%0d_data", a), cur_bus, exp_q.pop_front());
    if (!hold) begin
      req = 1'b0;
      @(posedge clk); #1;
      check($sformatf("rd%0d_release", a), {cur_rel, cur_ack, cur_busy}, 3'b100);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0;
    tb_data = '0; tb_drive = 1'b0; sel16 = 1'b0;
    model_clear();
    #2;
    check("reset_outputs", {cur_ack, cur_busy, cur_err, cur_rel}, 4'b0001);
    #10 rst = 1'b1;

    // Reset in the middle of RD_ACK, with req still held high across the release
    do_write(3, 32'hA5A5_5A5A, 1'b0);
    do_read(3, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid_reset_async", {cur_rel, cur_ack, cur_busy}, 3'b100);
    model_clear();
    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("req_held_after_reset_idle", {cur_busy, cur_ack}, 2'b00);
    req = 1'b0;
    do_read(3, 1'b0, 1'b0);

    // Basic write then read
    do_write(5, 32'hDEAD_BEEF, 1'b0);
    do_read(5, 1'b0, 1'b0);

    // Hardwired-zero register and address 0
    do_write(31, 32'h1234_5678, 1'b0);
    do_read(31, 1'b0, 1'b0);
    do_write(0, 32'h1234_5678, 1'b0);
    do_read(0, 1'b0, 1'b0);

    // Abort a write one cycle after req rises
    do_write(7, 32'h0000_0777, 1'b0);
    @(posedge clk); #1;
    addr = 5'd7; we = 1'b1; tb_data = 32'hBAD0_BAD0; tb_drive = 1'b1; req = 1'b1;
    @(posedge clk); #1;
    check("abort_busy_rises", {cur_busy, cur_ack}, 2'b10);
    req = 1'b0; tb_drive = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", {cur_busy, cur_ack}, 2'b00);
    do_read(7, 1'b0, 1'b0);

    // Back-to-back: ack holds while req held, then req low one cycle starts a new read
    do_read(5, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("hold_ack_busy", {cur_ack, cur_busy, cur_rel}, 3'b110);
    req = 1'b0;
    do_read(0, 1'b0, 1'b0);

    // 16-deep instance: out-of-range access flags err but still completes
    sel16 = 1'b1;
    do_write(20, 32'hCAFE_F00D, 1'b1);
    do_read(20, 1'b1, 1'b0);
    do_write(4, 32'h0000_0044, 1'b0);
    do_read(4, 1'b0, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
